carrega_instrucao: RTL and testbench
====================================

# carrega_instrucao

Program loader that fills the instruction memory before the multicycle core starts fetching. It accepts a byte stream over a valid/ready handshake and packs every four bytes, MSB first, into one 32-bit instruction. It writes each word to consecutive instruction-memory addresses starting at 0, and reports completion so the control unit can release the fetch stage (fetch state `4'b0000`).

## Interface
Parameters:
- `NUM_PALAVRAS`, default 10: instruction-memory depth in words.
- `ADDR_W`, default 4: address width, with 2^ADDR_W >= NUM_PALAVRAS.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `iniciar`, in, 1: one-cycle pulse that starts or restarts a load session.
- `finalizar`, in, 1: one-cycle pulse that ends the session early.
- `byte_dado`, in, 8: stream byte.
- `byte_valido`, in, 1: `byte_dado` is valid.
- `byte_pronto`, out, 1: loader can accept a byte.
- `mem_escreve`, out, 1: one-cycle write strobe to instruction memory.
- `mem_endereco`, out, ADDR_W: write address.
- `mem_dado`, out, 32: write data.
- `carregando`, out, 1: a session is in progress.
- `concluido`, out, 1: the session has ended; held until the next `iniciar`.
- `erro`, out, 1: the session ended with a partial word discarded.
- `total_palavras`, out, ADDR_W+1: number of words written this session.
- `checksum`, out, 32: XOR of all written words (see Configuration).

## Operation
The state machine has four states: OCIOSO, RECEBE, ESCREVE and FIM.

- **OCIOSO** (reset state): `byte_pronto`=0. `iniciar` clears `total_palavras`, the byte counter, the word register, `erro` and `checksum`, then moves to RECEBE.
- **RECEBE**: `byte_pronto`=1 and `carregando`=1.
  - A byte is accepted when `byte_valido` and `byte_pronto` are both high. On accept: word <= {word[23:0], `byte_dado`} and the byte counter increments (2 bits).
  - The 4th accepted byte moves the FSM to ESCREVE.
- **ESCREVE**: lasts exactly one cycle.
  - Drives `mem_escreve`=1, `mem_endereco`=`total_palavras`[ADDR_W-1:0] and `mem_dado`=word. `byte_pronto`=0.
  - Next edge: `total_palavras` increments.
  - If the new count equals `NUM_PALAVRAS`, go to FIM; otherwise return to RECEBE with the byte counter at 0.
- **FIM**: `concluido`=1, `carregando`=0, `byte_pronto`=0. Stays in FIM until `iniciar`.
- **`finalizar` in RECEBE**: go to FIM.
  - If the byte counter is nonzero, the partial word is dropped, `erro` is set to 1 and no write occurs.
  - A byte accepted in the same cycle is discarded.
- **`finalizar` in other states**: ignored in OCIOSO, ESCREVE and FIM.
- **`iniciar` in any state** (including mid-session): synchronous restart into RECEBE with all counters cleared.
  - `iniciar` has priority over `finalizar`, over byte accept, and over an ESCREVE completing in the same cycle.
  - That ESCREVE write still occurs, because `mem_escreve` is combinational from the state, but the count is cleared.
- **Address range**: addresses never exceed `NUM_PALAVRAS`-1, and the counter never wraps within a session.
- **Output stability**: `mem_dado` and `mem_endereco` are don't-care while `mem_escreve`=0, but are held stable (registered).

## Timing
- **Reset values**: state OCIOSO. `byte_pronto`, `mem_escreve`, `carregando`, `concluido` and `erro` are 0. `mem_endereco`, `mem_dado`, `total_palavras` and `checksum` are 0.
- **Reset mid-operation**: asserting `rst_n` low mid-operation returns to OCIOSO immediately. No `mem_escreve` is asserted after reset asserts.
- **Start latency**: `iniciar` at edge N gives `byte_pronto`=1 in the cycle after edge N.
- **Throughput**: minimum 5 cycles per word (4 accepts + 1 write). Stalls on `byte_valido`=0 are unbounded.
- **Write latency**: the write strobe appears in the cycle after the edge that accepts the 4th byte.
- **Completion**: `concluido` rises in the cycle after the final ESCREVE.

## Configuration
- **`CARREGA_CHECKSUM_EN` defined**: on each ESCREVE, `checksum` <= `checksum` ^ `mem_dado`. The value is held in FIM and cleared on `iniciar`.
- **`CARREGA_CHECKSUM_EN` undefined**: no accumulator register; `checksum` is tied to 32'h0.

## Test plan
1. **Full load.** `NUM_PALAVRAS`=10; `iniciar`, then 40 bytes 0x00..0x27 back-to-back.
   - Writes: address 0 = 32'h00010203, …, address 9 = 32'h24252627.
   - `concluido`=1 and `total_palavras`=10 in the cycle after the 10th write.
2. **Backpressure and gaps.** Drop `byte_valido` randomly across 8 bytes 0xDE 0xAD 0xBE 0xEF 0x01 0x02 0x03 0x04.
   - Exactly two writes: 32'hDEADBEEF at address 0 and 32'h01020304 at address 1.
   - No byte is accepted while `byte_pronto`=0.
3. **Early finalizar with a partial word.** 6 bytes, then `finalizar`.
   - One write only; `erro`=1, `concluido`=1, `total_palavras`=1.
   - `finalizar` after exactly 8 bytes instead gives `erro`=0.
4. **Restart mid-session.** `iniciar` after 2 words plus 3 bytes, then 4 bytes 0xAA 0xBB 0xCC 0xDD.
   - Next write is 32'hAABBCCDD at address 0; `total_palavras`=1.
5. **Async reset.** Assert `rst_n`=0 mid-word, between clock edges.
   - All outputs go to 0 immediately; state is OCIOSO; bytes are ignored until `iniciar`.
6. **Checksum, with `CARREGA_CHECKSUM_EN`.** Words 32'h0000FFFF and 32'hFFFF0000 with `NUM_PALAVRAS`=2.
   - `checksum`=32'hFFFFFFFF.
   - Without the macro, `checksum`=0 throughout.

Source files
------------

// File: rtl/carrega_instrucao.sv
// Program loader: packs a valid/ready byte stream MSB-first into 32-bit words for instruction memory.
// Optional macro CARREGA_CHECKSUM_EN adds an XOR accumulator over the written words.
module carrega_instrucao #(
    parameter int NUM_PALAVRAS = 10,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iniciar,
    input  logic              finalizar,
    input  logic [7:0]        byte_dado,
    input  logic              byte_valido,
    output logic              byte_pronto,
    output logic              mem_escreve,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [31:0]       mem_dado,
    output logic              carregando,
    output logic              concluido,
    output logic              erro,
    output logic [ADDR_W:0]   total_palavras,
    output logic [31:0]       checksum
);

    // state   | meaning
    // OCIOSO  | idle after reset, waiting for iniciar
    // RECEBE  | accepting stream bytes
    // ESCREVE | one-cycle write strobe of the packed word
    // FIM     | session ended, held until iniciar
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        RECEBE  = 2'd1,
        ESCREVE = 2'd2,
        FIM     = 2'd3
    } estado_t;

    localparam logic [ADDR_W:0] TOTAL_MAX = (ADDR_W+1)'(NUM_PALAVRAS);

    estado_t           estado, prox_estado;
    logic [23:0]       palavra;
    logic [1:0]        cnt_byte;
    logic [ADDR_W:0]   total;
    logic              erro_r;
    logic [31:0]       dado_r;
    logic [ADDR_W-1:0] end_r;
    logic              aceita;
    logic              ultimo_byte;
    logic              fim_sessao;

    assign aceita      = byte_valido && byte_pronto;
    assign ultimo_byte = aceita && (cnt_byte == 2'd3);
    assign fim_sessao  = (total + 1'b1) == TOTAL_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= OCIOSO;
        else        estado <= prox_estado;
    end

    always_comb begin
        prox_estado = estado;
        if (iniciar) begin
            prox_estado = RECEBE;
        end else begin
            case (estado)
                RECEBE: begin
                    if (finalizar)        prox_estado = FIM;
                    else if (ultimo_byte) prox_estado = ESCREVE;
                end
                ESCREVE: prox_estado = fim_sessao ? FIM : RECEBE;
                default: prox_estado = estado;
            endcase
        end
    end

    always_comb begin
        byte_pronto = 1'b0;
        mem_escreve = 1'b0;
        carregando  = 1'b0;
        concluido   = 1'b0;
        case (estado)
            RECEBE: begin
                byte_pronto = 1'b1;
                carregando  = 1'b1;
            end
            ESCREVE: begin
                mem_escreve = 1'b1;
                carregando  = 1'b1;
            end
            FIM:     concluido = 1'b1;
            default: ;
        endcase
    end

    // Only the three earlier bytes are kept; the fourth is merged straight into dado_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            palavra  <= '0;
            cnt_byte <= '0;
            total    <= '0;
            erro_r   <= 1'b0;
            dado_r   <= '0;
            end_r    <= '0;
        end else if (iniciar) begin
            palavra  <= '0;
            cnt_byte <= '0;
            total    <= '0;
            erro_r   <= 1'b0;
        end else begin
            case (estado)
                RECEBE: begin
                    if (finalizar) begin
                        erro_r <= (cnt_byte != 2'd0);
                    end else if (aceita) begin
                        palavra  <= {palavra[15:0], byte_dado};
                        cnt_byte <= cnt_byte + 2'd1;
                        if (cnt_byte == 2'd3) begin
                            dado_r <= {palavra, byte_dado};
                            end_r  <= total[ADDR_W-1:0];
                        end
                    end
                end
                ESCREVE: total <= total + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CARREGA_CHECKSUM_EN
    logic [31:0] soma_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  soma_r <= '0;
        else if (iniciar)            soma_r <= '0;
        else if (estado == ESCREVE)  soma_r <= soma_r ^ dado_r;
    end

    assign checksum = soma_r;
`else
    assign checksum = 32'h0;
`endif

    assign mem_endereco   = end_r;
    assign mem_dado       = dado_r;
    assign total_palavras = total;
    assign erro           = erro_r;

endmodule

// File: tb/tb_carrega_instrucao.sv
// Directed self-checking bench for carrega_instrucao (NUM_PALAVRAS=10, ADDR_W=4).
module tb_carrega_instrucao;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iniciar = 1'b0;
    logic        finalizar = 1'b0;
    logic [7:0]  byte_dado = 8'h00;
    logic        byte_valido = 1'b0;
    logic        byte_pronto;
    logic        mem_escreve;
    logic [3:0]  mem_endereco;
    logic [31:0] mem_dado;
    logic        carregando;
    logic        concluido;
    logic        erro;
    logic [4:0]  total_palavras;
    logic [31:0] checksum;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    logic [3:0]  wq_addr[$];
    logic [31:0] wq_data[$];

    carrega_instrucao #(.NUM_PALAVRAS(10), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .finalizar(finalizar),
        .byte_dado(byte_dado), .byte_valido(byte_valido), .byte_pronto(byte_pronto),
        .mem_escreve(mem_escreve), .mem_endereco(mem_endereco), .mem_dado(mem_dado),
        .carregando(carregando), .concluido(concluido), .erro(erro),
        .total_palavras(total_palavras), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, so the falling edge sees what the next edge samples.
    always @(negedge clk) begin
        if (mem_escreve) begin
            wq_addr.push_back(mem_endereco);
            wq_data.push_back(mem_dado);
        end
        if (byte_valido && byte_pronto) acc_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_dado   = b;
        byte_valido = 1'b1;
        @(negedge clk);
        while (!byte_pronto && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed %0d expected <50", n);
        end
        @(posedge clk);
        #1;
        byte_valido = 1'b0;
    endtask

    task automatic pulse_ini();
        iniciar = 1'b1;
        @(posedge clk);
        #1;
        iniciar = 1'b0;
    endtask

    task automatic pulse_fin();
        finalizar = 1'b1;
        @(posedge clk);
        #1;
        finalizar = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_w;
        logic [31:0] exp_ck;
        int a0;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pronto", byte_pronto, 0);
        chk("rst_escreve", mem_escreve, 0);
        chk("rst_carregando", carregando, 0);
        chk("rst_concluido", concluido, 0);
        chk("rst_erro", erro, 0);
        chk("rst_end", mem_endereco, 0);
        chk("rst_dado", mem_dado, 0);
        chk("rst_total", total_palavras, 0);
        chk("rst_checksum", checksum, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: full load of 40 back-to-back bytes
        pulse_ini();
        chk("t1_start_pronto", byte_pronto, 1);
        chk("t1_start_carregando", carregando, 1);
        exp_ck = 32'h0;
        for (int i = 0; i < 40; i++) begin
            send_byte(8'(i));
            if (i % 4 == 3) begin
                exp_w = {8'(i-3), 8'(i-2), 8'(i-1), 8'(i)};
`ifdef CARREGA_CHECKSUM_EN
                exp_ck = exp_ck ^ exp_w;
`endif
                chk("t1_strobe", mem_escreve, 1);
                chk("t1_addr", mem_endereco, 32'(i / 4));
                chk("t1_data", mem_dado, exp_w);
            end
        end
        chk("t1_concl_before", concluido, 0);
        @(posedge clk);
        #1;
        chk("t1_concluido", concluido, 1);
        chk("t1_total", total_palavras, 10);
        chk("t1_carregando", carregando, 0);
        chk("t1_pronto", byte_pronto, 0);
        chk("t1_erro", erro, 0);
        chk("t1_checksum", checksum, exp_ck);
        chk("t1_nwrites", wq_data.size(), 10);
        chk("t1_w0", wq_data[0], 32'h00010203);
        chk("t1_a9", wq_addr[9], 9);
        chk("t1_w9", wq_data[9], 32'h24252627);

        // 2: gaps on byte_valido, including requests during ESCREVE
        pulse_ini();
        wq_addr.delete();
        wq_data.delete();
        a0 = acc_cnt;
        begin
            logic [7:0] seq [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                send_byte(seq[i]);
            end
        end
        @(posedge clk);
        #1;
        chk("t2_accepts", acc_cnt - a0, 8);
        chk("t2_nwrites", wq_data.size(), 2);
        chk("t2_w0", wq_data[0], 32'hDEADBEEF);
        chk("t2_a0", wq_addr[0], 0);
        chk("t2_w1", wq_data[1], 32'h01020304);
        chk("t2_a1", wq_addr[1], 1);
        chk("t2_total", total_palavras, 2);

        // 3: finalizar with a partial word, then on a word boundary
        pulse_ini();
        wq_addr.delete();
        wq_data.delete();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i));
        pulse_fin();
        chk("t3_erro", erro, 1);
        chk("t3_concluido", concluido, 1);
        chk("t3_total", total_palavras, 1);
        chk("t3_nwrites", wq_data.size(), 1);
        chk("t3_w0", wq_data[0], 32'h10111213);
        pulse_ini();
        chk("t3_erro_cleared", erro, 0);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h20 + i));
        @(posedge clk);
        #1;
        pulse_fin();
        chk("t3b_erro", erro, 0);
        chk("t3b_concluido", concluido, 1);
        chk("t3b_total", total_palavras, 2);

        // 4: restart after 2 words plus 3 bytes
        pulse_ini();
        for (int i = 0; i < 11; i++) send_byte(8'(8'h50 + i));
        pulse_ini();
        chk("t4_total_clr", total_palavras, 0);
        chk("t4_pronto", byte_pronto, 1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        chk("t4_strobe", mem_escreve, 1);
        chk("t4_addr", mem_endereco, 0);
        chk("t4_data", mem_dado, 32'hAABBCCDD);
        @(posedge clk);
        #1;
        chk("t4_total", total_palavras, 1);

        // 5: async reset between edges mid-word
        send_byte(8'h77);
        send_byte(8'h88);
        wq_addr.delete();
        wq_data.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_pronto", byte_pronto, 0);
        chk("t5_carregando", carregando, 0);
        chk("t5_escreve", mem_escreve, 0);
        chk("t5_dado", mem_dado, 0);
        chk("t5_end", mem_endereco, 0);
        chk("t5_total", total_palavras, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a0 = acc_cnt;
        byte_dado   = 8'h99;
        byte_valido = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        byte_valido = 1'b0;
        chk("t5_no_accept", acc_cnt - a0, 0);
        chk("t5_no_write", wq_data.size(), 0);
        chk("t5_concluido", concluido, 0);

        // 6: checksum over 0000FFFF and FFFF0000
        pulse_ini();
        chk("t6_ck_clr", checksum, 0);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hFF);
        chk("t6_addr0", mem_endereco, 0);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h00);
        @(posedge clk);
        #1;
        chk("t6_total", total_palavras, 2);
`ifdef CARREGA_CHECKSUM_EN
        chk("t6_checksum", checksum, 32'hFFFFFFFF);
`else
        chk("t6_checksum", checksum, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
